// File: rtl/cmos_upload_reader_if.sv
// Bus bundle between data_io, the game CMOS read port and the NVRAM
// upload reader. The master side is the environment (data_io plus the
// CMOS RAM and game write strobe); the slave side is the reader itself.
interface cmos_upload_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
);
    logic              ioctl_upload;
    logic [7:0]        ioctl_index;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_din;
    logic [ADDR_W-1:0] cmos_addr;
    logic              cmos_rd;
    logic [DATA_W-1:0] cmos_q;
    logic              game_cmos_we;
    logic              upl_ready;
    logic              snap_busy;
    logic              nvram_dirty;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_addr, cmos_q, game_cmos_we,
        input  ioctl_din, cmos_addr, cmos_rd, upl_ready, snap_busy, nvram_dirty
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_addr, cmos_q, game_cmos_we,
        output ioctl_din, cmos_addr, cmos_rd, upl_ready, snap_busy, nvram_dirty
    );
endinterface

// File: rtl/cmos_upload_reader.sv
// NVRAM upload reader. When data_io starts the NVRAM upload, the game CMOS
// is copied through its dedicated read port into a local buffer, and data_io
// reads are served from that buffer so game writes cannot tear the saved
// image. Game writes are also tracked to flag unsaved NVRAM changes.
module cmos_upload_reader #(
    parameter int         ADDR_W    = 8,
    parameter int         DATA_W    = 4,
    parameter logic [7:0] PAD       = 8'h0F,
    parameter logic [7:0] UPL_INDEX = 8'hFF
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    cmos_upload_reader_if.slave  bus
);

    localparam int                DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNAP  = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic              upl_go;
    logic              upl_go_q;
    logic              start;
    logic              snap_end;
    logic              wr_seen;
    logic              dirty_q;
    logic              vld_p1;
    logic [ADDR_W-1:0] cap_addr_p1;
    logic [DATA_W-1:0] snap_buf [DEPTH];
    logic [7:0]        din_q;

    // Widen a CMOS word to a byte, filling the unused upper bits with PAD.
    function automatic logic [7:0] pad_byte(input logic [DATA_W-1:0] d);
        logic [7:0] b;
        b = '0;
        b[DATA_W-1:0] = d;
        return b | (PAD << DATA_W);
    endfunction

    assign upl_go = bus.ioctl_upload && (bus.ioctl_index == UPL_INDEX);
    // Only a fresh rising edge of upl_go starts a snapshot, so an index
    // switch while the reader is already serving is ignored.
    assign start  = upl_go && !upl_go_q;

    // State register, snapshot counter and upl_go edge history.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            upl_go_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            upl_go_q <= upl_go;
        end
    end

    // Next-state logic; the counter stops at the top address and never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        snap_end  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SNAP;
                    cnt_nxt   = '0;
                end
            end
            SNAP: begin
                if (!upl_go) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DRAIN;
                    snap_end  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (!upl_go) state_nxt = IDLE;
                else         state_nxt = READY;
            end
            READY: begin
                if (!upl_go) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Dirty tracking: a write always sets the flag. A completed snapshot
    // clears it only if no write landed while the copy was running, since
    // such a write may have hit an address that was already copied.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_seen <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            if (state == IDLE && start)
                wr_seen <= 1'b0;
            else if (bus.game_cmos_we && (state == SNAP || state == DRAIN))
                wr_seen <= 1'b1;
            dirty_q <= bus.game_cmos_we || (dirty_q && !(snap_end && !wr_seen));
        end
    end

    // Capture valid: a read issued this clk returns data on the next clk.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) vld_p1 <= 1'b0;
        else          vld_p1 <= (state == SNAP);
    end

    // ---- stage p1: read address registered, cmos_q lands in the buffer ----
    always_ff @(posedge clk_sys) begin
        cap_addr_p1 <= cnt;
        if (vld_p1) snap_buf[cap_addr_p1] <= bus.cmos_q;
    end

    // Registered read-back to data_io, updated only while our upload is active.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)    din_q <= '0;
        else if (upl_go) din_q <= pad_byte(snap_buf[bus.ioctl_addr]);
    end

    assign bus.ioctl_din   = din_q;
    assign bus.cmos_addr   = cnt;
    assign bus.cmos_rd     = (state == SNAP);
    assign bus.upl_ready   = (state == READY);
    assign bus.snap_busy   = (state == SNAP) || (state == DRAIN);
    assign bus.nvram_dirty = dirty_q;

endmodule
